// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute micro-sequencer with timer trap for the FPG8 single-bus datapath
module control_sequencer #(
  parameter logic [2:0] PC_SEL   = 3'd7,
  parameter logic [2:0] LINK_SEL = 3'd6,
  parameter logic [2:0] ALU_ADD  = 3'd0,
  parameter logic [2:0] ALU_SUB  = 3'd1,
  parameter logic [2:0] ALU_AND  = 3'd2,
  parameter logic [2:0] ALU_OR   = 3'd3,
  parameter logic [2:0] ALU_INC  = 3'd4
) (
  input  logic       one_shot_clock,
  input  logic       reset,
  input  logic       dbg_hold,
  input  logic [3:0] opcode,
  input  logic       psw_z,
  input  logic       psw_n,
  input  logic       timeout,
  output logic       GPR_in,
  output logic       GPR_out,
  output logic       IR_in,
  output logic       MAR_in,
  output logic       MDR_in,
  output logic       MDR_out,
  output logic       PSW_in,
  output logic       PSW_out,
  output logic       RAM_enable_read,
  output logic       RAM_enable_write,
  output logic       timer_in,
  output logic       con_ROM_out,
  output logic       Y_in,
  output logic       Y_out,
  output logic       Y_offset_in,
  output logic       Y_shift_left,
  output logic       Y_shift_right,
  output logic       Z_in,
  output logic       Z_out,
  output logic [2:0] GPR_select,
  output logic [2:0] ALU_control,
  output logic       halted,
  output logic [3:0] step
);
  typedef enum logic [3:0] {F0, F1, F2, E0, E1, E2, T0, T1, T2, HALT} state_t;
  state_t state_q, state_d, boundary;
  logic arith, load, store, taken, set_timer;
  logic [2:0] alu_op;
  assign arith     = opcode <= 4'd3;
  assign load      = opcode == 4'd4;
  assign store     = opcode == 4'd5;
  assign set_timer = opcode == 4'd9;
  assign taken     = opcode == 4'd6 || (opcode == 4'd7 && psw_z) || (opcode == 4'd8 && psw_n);
  assign alu_op    = opcode[1:0] == 2'd0 ? ALU_ADD : opcode[1:0] == 2'd1 ? ALU_SUB :
                     opcode[1:0] == 2'd2 ? ALU_AND : ALU_OR;
  // timeout only matters when an instruction finishes and the next fetch would begin
  assign boundary  = timeout ? T0 : F0;
  assign PSW_in        = 1'b0;
  assign PSW_out       = 1'b0;
  assign Y_offset_in   = 1'b0;
  assign Y_shift_left  = 1'b0;
  assign Y_shift_right = 1'b0;
  assign halted        = state_q == HALT;
  assign step          = state_q;
  always_ff @(posedge one_shot_clock) begin
    if (reset) state_q <= F0;
    else state_q <= state_d;
  end
  always_comb begin
    state_d          = state_q;
    GPR_in           = 1'b0;
    GPR_out          = 1'b0;
    IR_in            = 1'b0;
    MAR_in           = 1'b0;
    MDR_in           = 1'b0;
    MDR_out          = 1'b0;
    RAM_enable_read  = 1'b0;
    RAM_enable_write = 1'b0;
    timer_in         = 1'b0;
    con_ROM_out      = 1'b0;
    Y_in             = 1'b0;
    Y_out            = 1'b0;
    Z_in             = 1'b0;
    Z_out            = 1'b0;
    GPR_select       = 3'd0;
    ALU_control      = ALU_ADD;
    if (!dbg_hold) begin
      case (state_q)
        F0: state_d = F1;
        F1: state_d = F2;
        F2: state_d = E0;
        E0: state_d = opcode == 4'd15 ? HALT : (arith || load || store || taken) ? E1 : boundary;
        E1: state_d = (arith || load || store) ? E2 : boundary;
        E2: state_d = boundary;
        T0: state_d = T1;
        T1: state_d = T2;
        T2: state_d = F0;
        default: state_d = state_q;
      endcase
    end
    if (!dbg_hold && !reset) begin
      case (state_q)
        F0: begin
          GPR_out     = 1'b1;
          GPR_select  = PC_SEL;
          MAR_in      = 1'b1;
          ALU_control = ALU_INC;
          Z_in        = 1'b1;
        end
        F1: begin
          RAM_enable_read = 1'b1;
          Z_out           = 1'b1;
          GPR_in          = 1'b1;
          GPR_select      = PC_SEL;
        end
        F2: begin
          MDR_out = 1'b1;
          IR_in   = 1'b1;
        end
        E0: begin
          GPR_out    = arith || load || store || taken || set_timer;
          GPR_select = GPR_out ? 3'd2 : 3'd0;
          Y_in       = arith || taken;
          MAR_in     = load || store;
          timer_in   = set_timer;
        end
        E1: begin
          if (arith) begin
            GPR_out     = 1'b1;
            GPR_select  = 3'd3;
            ALU_control = alu_op;
            Z_in        = 1'b1;
          end else if (load) begin
            RAM_enable_read = 1'b1;
          end else if (store) begin
            GPR_out    = 1'b1;
            GPR_select = 3'd3;
            MDR_in     = 1'b1;
          end else begin
            Y_out      = 1'b1;
            GPR_in     = 1'b1;
            GPR_select = PC_SEL;
          end
        end
        E2: begin
          Z_out            = arith;
          MDR_out          = load;
          GPR_in           = arith || load;
          RAM_enable_write = store;
        end
        T0: begin
          GPR_out    = 1'b1;
          GPR_select = PC_SEL;
          Y_in       = 1'b1;
        end
        T1: begin
          Y_out      = 1'b1;
          GPR_in     = 1'b1;
          GPR_select = LINK_SEL;
        end
        T2: begin
          con_ROM_out = 1'b1;
          GPR_in      = 1'b1;
          GPR_select  = PC_SEL;
          timer_in    = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
